// File: rtl/hex_step_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hex_step_decoder_pkg
// Description : Shared segment patterns, step-command codes and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package hex_step_decoder_pkg;

    // Active-low patterns, bit 6 = segment g ... bit 0 = segment a
    localparam logic [6:0] C_SEG_0 = 7'b1000000;
    localparam logic [6:0] C_SEG_1 = 7'b1111001;
    localparam logic [6:0] C_SEG_2 = 7'b0100100;
    localparam logic [6:0] C_SEG_3 = 7'b0110000;
    localparam logic [6:0] C_SEG_4 = 7'b0011001;
    localparam logic [6:0] C_SEG_5 = 7'b0010010;
    localparam logic [6:0] C_SEG_6 = 7'b0000010;
    localparam logic [6:0] C_SEG_7 = 7'b1111000;
    localparam logic [6:0] C_SEG_8 = 7'b0000000;
    localparam logic [6:0] C_SEG_9 = 7'b0010000;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_INC1 = 2'b01;
    localparam logic [1:0] CMD_INC2 = 2'b10;
    localparam logic [1:0] CMD_DEC1 = 2'b11;

    localparam logic [7:0] C_CNT_MAX = 8'd255;

    localparam logic [0:0] C_ST_EMPTY = 1'b0;
    localparam logic [0:0] C_ST_TRACK = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = C_ST_EMPTY,
        ST_TRACK = C_ST_TRACK
    } state_t;

endpackage : hex_step_decoder_pkg
`default_nettype wire

// File: rtl/hex_step_decoder_seg7_to_bcd.sv
`default_nettype none
// ============================================================================
// Module      : seg7_to_bcd
// Description : Combinational active-low 7-segment to decimal digit lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_to_bcd
    import hex_step_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        unique case (seg)
            C_SEG_0: digit = 4'd0;
            C_SEG_1: digit = 4'd1;
            C_SEG_2: digit = 4'd2;
            C_SEG_3: digit = 4'd3;
            C_SEG_4: digit = 4'd4;
            C_SEG_5: digit = 4'd5;
            C_SEG_6: digit = 4'd6;
            C_SEG_7: digit = 4'd7;
            C_SEG_8: digit = 4'd8;
            C_SEG_9: digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule : seg7_to_bcd
`default_nettype wire

// File: rtl/hex_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hex_step_decoder
// Description : Tracks successive 7-segment digits and recovers step commands.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_step_decoder
    import hex_step_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       sample,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic [1:0] cmd,
    output logic       cmd_valid,
    output logic       seg_err,
    output logic       jump_err,
    output logic [7:0] cmd_count
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_prev;
    logic [3:0] r_digit;
    logic [1:0] r_cmd;
    logic [7:0] r_cmd_count;
    logic       r_digit_valid;
    logic       r_cmd_valid;
    logic       r_seg_err;
    logic       r_jump_err;

    logic [3:0] w_prev_nxt;
    logic [3:0] w_digit_nxt;
    logic [1:0] w_cmd_nxt;
    logic [7:0] w_cmd_count_nxt;
    logic       w_digit_valid_nxt;
    logic       w_cmd_valid_nxt;
    logic       w_seg_err_nxt;
    logic       w_jump_err_nxt;

    logic [3:0] w_new;
    logic       w_legal;
    logic [4:0] w_diff;
    logic [4:0] w_delta;

    seg7_to_bcd u_lookup (
        .seg   (seg_in),
        .digit (w_new),
        .legal (w_legal)
    );

    // Bias by 10 before subtracting so the 5-bit difference never underflows
    assign w_diff  = {1'b0, w_new} + 5'd10 - {1'b0, r_prev};
    assign w_delta = (w_diff >= 5'd10) ? (w_diff - 5'd10) : w_diff;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_prev_nxt        = r_prev;
        w_digit_nxt       = r_digit;
        w_cmd_nxt         = r_cmd;
        w_cmd_count_nxt   = r_cmd_count;
        w_digit_valid_nxt = 1'b0;
        w_cmd_valid_nxt   = 1'b0;
        w_seg_err_nxt     = 1'b0;
        w_jump_err_nxt    = 1'b0;

        if (sample) begin
            if (!w_legal) begin
                w_seg_err_nxt = 1'b1;
                w_state_nxt   = ST_EMPTY;
            end else begin
                w_prev_nxt        = w_new;
                w_digit_nxt       = w_new;
                w_digit_valid_nxt = 1'b1;
                w_state_nxt       = ST_TRACK;
                if (r_state == ST_TRACK) begin
                    w_cmd_valid_nxt = 1'b1;
                    case (w_delta)
                        5'd0:    w_cmd_nxt = CMD_HOLD;
                        5'd1:    w_cmd_nxt = CMD_INC1;
                        5'd2:    w_cmd_nxt = CMD_INC2;
                        5'd9:    w_cmd_nxt = CMD_DEC1;
                        default: begin
                            w_cmd_valid_nxt = 1'b0;
                            w_jump_err_nxt  = 1'b1;
                        end
                    endcase
                end
            end
        end

        if (w_cmd_valid_nxt && (r_cmd_count != C_CNT_MAX)) begin
            w_cmd_count_nxt = r_cmd_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev        <= 4'd0;
            r_digit       <= 4'd0;
            r_cmd         <= CMD_HOLD;
            r_cmd_count   <= 8'd0;
            r_digit_valid <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_seg_err     <= 1'b0;
            r_jump_err    <= 1'b0;
        end else begin
            r_prev        <= w_prev_nxt;
            r_digit       <= w_digit_nxt;
            r_cmd         <= w_cmd_nxt;
            r_cmd_count   <= w_cmd_count_nxt;
            r_digit_valid <= w_digit_valid_nxt;
            r_cmd_valid   <= w_cmd_valid_nxt;
            r_seg_err     <= w_seg_err_nxt;
            r_jump_err    <= w_jump_err_nxt;
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign cmd         = r_cmd;
    assign cmd_valid   = r_cmd_valid;
    assign seg_err     = r_seg_err;
    assign jump_err    = r_jump_err;
    assign cmd_count   = r_cmd_count;

endmodule : hex_step_decoder
`default_nettype wire
